ps2_key_sequencer: RTL and testbench
====================================

# ps2_key_sequencer

Controller between the PS/2 keyboard receiver FIFO and the display/consumer logic. It pops scan-code bytes through the receiver's `ready`/`nextdata_n` handshake and decodes the `E0` extended and `F0` break prefixes into single key events. It also tracks the currently held key and counts key presses. It replaces the free-running tie-low of `nextdata_n`, so exactly one FIFO byte is consumed per handshake.

## Interface
- `COUNT_W`, default 8: width of the press counter.

- `clk` in 1: system clock, all state on rising edge.
- `clrn` in 1: reset, asynchronous, active-low.
- `ready` in 1: receiver FIFO non-empty.
- `data` in 8: receiver FIFO head byte, valid while `ready`=1.
- `overflow` in 1: receiver FIFO overflow indication.
- `clear_ovf` in 1: synchronous clear of `ovf_sticky`.
- `nextdata_n` out 1: active-low pop strobe to the receiver.
- `key_event` out 1: one-cycle pulse, a decoded key event.
- `key_make` out 1: 1 = make, 0 = break; qualified by `key_event` and held until the next event.
- `key_ext` out 1: event carried the `E0` prefix.
- `key_code` out 8: code byte of the last event.
- `key_pressed` out 1: a key is currently held.
- `press_count` out COUNT_W: number of make events, wraps.
- `ovf_sticky` out 1: an overflow has been seen since the last clear.

## Operation
FSM states:
- **IDLE**: on `ready`=1, latch `data`, decode it, go to POP.
- **POP**: drive `nextdata_n`=0 for this one cycle, then go to SETTLE.
- **SETTLE**: ignore `ready` (the FIFO pointer is updating), then return to IDLE.

Decode, applied at the IDLE→POP edge:
- `E0`: set internal `ext_f`. No event.
- `F0`: set internal `brk_f`. No event. Repeated `F0`/`E0` bytes only re-set their flag.
- Any other byte is a code byte:
  - Emit an event with `key_code`=byte, `key_ext`=`ext_f`, `key_make`=!`brk_f`.
  - Clear `ext_f` and `brk_f`.
- Make event:
  - `held` ← {ext, code}.
  - `key_pressed` ← 1.
  - `press_count` ← `press_count`+1, mod 2^COUNT_W.
- Break event:
  - If {ext, code} equals `held` and `key_pressed`=1, then `key_pressed` ← 0.
  - Otherwise `key_pressed` is unchanged; the event is still emitted.
- Overflow:
  - `ovf_sticky` is set in any cycle with `overflow`=1.
  - `ovf_sticky` is cleared by `clear_ovf`=1.
  - Set wins when both occur in the same cycle.
  - Decoding continues normally after an overflow.

Reset values, applied immediately on `clrn`=0 in any state, including mid-POP:
- `nextdata_n`=1.
- `key_event`=0, `key_make`=0, `key_ext`=0, `key_code`=00, `key_pressed`=0.
- `press_count`=0, `ovf_sticky`=0.
- FSM in IDLE, `ext_f`=`brk_f`=0, `held`=0.

## Timing
- Edge E (IDLE, `ready`=1): in the following cycle `nextdata_n`=0, and `key_event`=1 if the byte completed an event.
- Edge E+1: `nextdata_n` ← 1, `key_event` ← 0.
- Edge E+2: SETTLE → IDLE.
- Earliest next byte sample: edge E+3. Sustained throughput is 1 byte per 3 cycles.
- `nextdata_n` is low for exactly one cycle per consumed byte and is never low in IDLE or SETTLE.
- `ready` is sampled only in IDLE.
- `key_code`, `key_make` and `key_ext` change only together with a `key_event` pulse.

## Configuration
- `PS2SEQ_REPEAT_FILTER_EN` defined:
  - A make whose {ext, code} equals `held` while `key_pressed`=1 is a typematic repeat.
  - A repeat produces no event and leaves `press_count` unchanged.
  - Flags are still cleared and the byte is still popped.
- Undefined: every make produces an event and increments `press_count`.

## Test plan
1. **Reset:** `clrn`=0 with `ready`=1 and `data`=1C → all outputs at their reset values, `nextdata_n` stays 1. Assert `clrn`=0 during POP → `nextdata_n` returns to 1 without waiting for a clock.
2. **Single make:** `ready`=1, `data`=1C → one cycle with `key_event`=1, `key_make`=1, `key_code`=1C, `key_ext`=0, coincident with the only cycle of `nextdata_n`=0. `press_count`=1, `key_pressed`=1. Next pop at E+3 or later.
3. **Make then break:** bytes 1C, F0, 1C → two events: make 1C, then break 1C. Then `key_pressed`=0, `press_count`=1.
4. **Extended and mismatched break:**
   - E0 75, then E0 F0 75 → events make ext 75, then break ext 75; `key_pressed` ends 0.
   - With 1C held, F0 22 → break event for 22; `key_pressed` stays 1.
5. **Repeat filter:** bytes 1C 1C 1C.
   - With `PS2SEQ_REPEAT_FILTER_EN`: 1 event, `press_count`=1, 3 pops.
   - Without it: 3 events, `press_count`=3.
6. **Counter wrap and overflow:**
   - 256 make/break pairs with COUNT_W=8 → `press_count`=0.
   - `overflow` pulse → `ovf_sticky`=1.
   - `clear_ovf` and `overflow` in the same cycle → `ovf_sticky` stays 1.
   - `clear_ovf` alone → `ovf_sticky`=0.

Source files
------------

// File: rtl/ps2_key_sequencer_if.sv
// PS/2 receiver FIFO side of ps2_key_sequencer: head byte, non-empty flag,
// overflow flag and the active-low pop strobe.
interface ps2_key_sequencer_if;
  logic       ready;
  logic [7:0] data;
  logic       overflow;
  logic       nextdata_n;

  // receiver FIFO (byte source)
  modport master (output ready, output data, output overflow, input nextdata_n);
  // key sequencer (byte consumer)
  modport slave  (input ready, input data, input overflow, output nextdata_n);
endinterface

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: pops one FIFO byte per handshake, folds E0/F0
// prefixes into single key events, tracks the held key and counts presses.
// Optional: define PS2SEQ_REPEAT_FILTER_EN to suppress typematic repeats.
module ps2_key_sequencer #(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               clrn,
  ps2_key_sequencer_if.slave rx,
  input  logic               clear_ovf,
  output logic               key_event,
  output logic               key_make,
  output logic               key_ext,
  output logic [7:0]         key_code,
  output logic               key_pressed,
  output logic [COUNT_W-1:0] press_count,
  output logic               ovf_sticky
);

  typedef enum logic [1:0] {IDLE, POP, SETTLE} state_e;

  state_e             state_q, state_d;
  logic               nextdata_n_q, nextdata_n_d;
  logic               key_event_q, key_event_d;
  logic               key_make_q, key_make_d;
  logic               key_ext_q, key_ext_d;
  logic [7:0]         key_code_q, key_code_d;
  logic               key_pressed_q, key_pressed_d;
  logic [COUNT_W-1:0] press_count_q, press_count_d;
  logic               ovf_sticky_q, ovf_sticky_d;
  logic               ext_f_q, ext_f_d;
  logic               brk_f_q, brk_f_d;
  logic [8:0]         held_q, held_d;
  logic               is_repeat;

  // state and output registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= IDLE;
      nextdata_n_q  <= 1'b1;
      key_event_q   <= 1'b0;
      key_make_q    <= 1'b0;
      key_ext_q     <= 1'b0;
      key_code_q    <= '0;
      key_pressed_q <= 1'b0;
      press_count_q <= '0;
      ovf_sticky_q  <= 1'b0;
      ext_f_q       <= 1'b0;
      brk_f_q       <= 1'b0;
      held_q        <= '0;
    end else begin
      state_q       <= state_d;
      nextdata_n_q  <= nextdata_n_d;
      key_event_q   <= key_event_d;
      key_make_q    <= key_make_d;
      key_ext_q     <= key_ext_d;
      key_code_q    <= key_code_d;
      key_pressed_q <= key_pressed_d;
      press_count_q <= press_count_d;
      ovf_sticky_q  <= ovf_sticky_d;
      ext_f_q       <= ext_f_d;
      brk_f_q       <= brk_f_d;
      held_q        <= held_d;
    end
  end

  // next-state, byte decode and key tracking
  always_comb begin
    state_d       = state_q;
    nextdata_n_d  = 1'b1;
    key_event_d   = 1'b0;
    key_make_d    = key_make_q;
    key_ext_d     = key_ext_q;
    key_code_d    = key_code_q;
    key_pressed_d = key_pressed_q;
    press_count_d = press_count_q;
    ext_f_d       = ext_f_q;
    brk_f_d       = brk_f_q;
    held_d        = held_q;
`ifdef PS2SEQ_REPEAT_FILTER_EN
    is_repeat     = !brk_f_q && key_pressed_q && (held_q == {ext_f_q, rx.data});
`else
    is_repeat     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (rx.ready) begin
          state_d      = POP;
          nextdata_n_d = 1'b0;
          if (rx.data == 8'hE0) begin
            ext_f_d = 1'b1;
          end else if (rx.data == 8'hF0) begin
            brk_f_d = 1'b1;
          end else begin
            ext_f_d = 1'b0;
            brk_f_d = 1'b0;
            if (!brk_f_q) begin
              if (!is_repeat) begin
                key_event_d   = 1'b1;
                key_make_d    = 1'b1;
                key_ext_d     = ext_f_q;
                key_code_d    = rx.data;
                press_count_d = press_count_q + COUNT_W'(1);
              end
              held_d        = {ext_f_q, rx.data};
              key_pressed_d = 1'b1;
            end else begin
              key_event_d = 1'b1;
              key_make_d  = 1'b0;
              key_ext_d   = ext_f_q;
              key_code_d  = rx.data;
              if (key_pressed_q && (held_q == {ext_f_q, rx.data})) begin
                key_pressed_d = 1'b0;
              end
            end
          end
        end
      end
      POP:     state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // set wins over clear
    if (rx.overflow) begin
      ovf_sticky_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_sticky_d = 1'b0;
    end else begin
      ovf_sticky_d = ovf_sticky_q;
    end
  end

  assign rx.nextdata_n = nextdata_n_q;
  assign key_event     = key_event_q;
  assign key_make      = key_make_q;
  assign key_ext       = key_ext_q;
  assign key_code      = key_code_q;
  assign key_pressed   = key_pressed_q;
  assign press_count   = press_count_q;
  assign ovf_sticky    = ovf_sticky_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench for ps2_key_sequencer: a FIFO model feeds bytes, a key
// model predicts events at push time, a monitor checks each presented event.
module tb_ps2_key_sequencer;

  localparam int unsigned COUNT_W = 8;

  logic               clk;
  logic               clrn;
  logic               clear_ovf;
  logic               key_event;
  logic               key_make;
  logic               key_ext;
  logic [7:0]         key_code;
  logic               key_pressed;
  logic [COUNT_W-1:0] press_count;
  logic               ovf_sticky;

  ps2_key_sequencer_if bus ();

  ps2_key_sequencer #(.COUNT_W(COUNT_W)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .rx          (bus.slave),
    .clear_ovf   (clear_ovf),
    .key_event   (key_event),
    .key_make    (key_make),
    .key_ext     (key_ext),
    .key_code    (key_code),
    .key_pressed (key_pressed),
    .press_count (press_count),
    .ovf_sticky  (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       make;
    logic       ext;
    logic [7:0] code;
    logic       pressed;
    int         count;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fifo[$];

  int tests    = 0;
  int fails    = 0;
  int pushed   = 0;
  int pops     = 0;
  int events   = 0;
  int exp_evts = 0;

  // key model state
  bit m_ext, m_brk, m_pressed;
  int m_held;   // {ext, code}, -1 when nothing was ever made
  int m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_pressed = 0; m_held = -1; m_count = 0;
  endtask

  // predict from the key-event rules, then hand the byte to the FIFO
  task automatic push_byte(input logic [7:0] b);
    ev_t e;
    int  key;
    bit  emit;
    fifo.push_back(b);
    pushed++;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      key  = (m_ext ? 256 : 0) + int'(b);
      emit = 1;
      if (!m_brk) begin
`ifdef PS2SEQ_REPEAT_FILTER_EN
        if (m_pressed && key == m_held) emit = 0;
`endif
        if (emit) m_count = (m_count + 1) % (1 << COUNT_W);
        m_held = key;
        m_pressed = 1;
      end else if (m_pressed && key == m_held) begin
        m_pressed = 0;
      end
      if (emit) begin
        e.make = !m_brk; e.ext = m_ext; e.code = b;
        e.pressed = m_pressed; e.count = m_count;
        exp_q.push_back(e);
        exp_evts++;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 5000 && fifo.size() != 0; i++) @(negedge clk);
    if (fifo.size() != 0) chk({name, "_timeout"}, 32'(fifo.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  // receiver FIFO model: pops on the strobe, presents the new head
  initial begin
    bus.ready = 1'b0; bus.data = 8'h00; bus.overflow = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.nextdata_n == 1'b0) begin
        if (fifo.size() != 0) void'(fifo.pop_front());
        pops++;
      end
      bus.ready = (fifo.size() != 0);
      bus.data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end
  end

  // monitor: event scoreboard plus strobe and output-stability checks
  initial begin
    ev_t        e;
    logic [7:0] last_code;
    logic       last_make, last_ext, prev_low;
    int         gap;
    last_code = 8'h00; last_make = 1'b0; last_ext = 1'b0; prev_low = 1'b0; gap = 3;
    forever begin
      @(negedge clk);
      if (!clrn) begin
        last_code = 8'h00; last_make = 1'b0; last_ext = 1'b0; prev_low = 1'b0; gap = 3;
        continue;
      end
      gap++;
      if (bus.nextdata_n == 1'b0) begin
        chk("pop_spacing_ok", 32'(gap >= 3), 32'd1);
        gap = 0;
      end
      if (key_event) begin
        events++;
        chk("event_with_pop", 32'(bus.nextdata_n), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("key_make", 32'(key_make), 32'(e.make));
          chk("key_ext", 32'(key_ext), 32'(e.ext));
          chk("key_code", 32'(key_code), 32'(e.code));
          chk("key_pressed_at_event", 32'(key_pressed), 32'(e.pressed));
          chk("press_count_at_event", 32'(press_count), 32'(e.count));
        end
        last_code = key_code; last_make = key_make; last_ext = key_ext;
      end else begin
        chk("key_fields_stable", {15'd0, last_make, last_ext, last_code, 7'd0},
            {15'd0, key_make, key_ext, key_code, 7'd0});
      end
      prev_low = (bus.nextdata_n == 1'b0);
    end
  end

  initial begin
    int ev0, pop0, cnt0, r;
    clrn = 1'b0; clear_ovf = 1'b0;
    model_reset();

    // reset held with a byte waiting
    push_byte(8'h1C);
    repeat (5) begin
      @(negedge clk);
      chk("rst_nextdata_n", 32'(bus.nextdata_n), 32'd1);
      chk("rst_key_event", 32'(key_event), 32'd0);
      chk("rst_outputs", {key_make, key_ext, key_code, key_pressed, ovf_sticky}, 32'd0);
      chk("rst_press_count", 32'(press_count), 32'd0);
    end
    clrn = 1'b1;
    drain("single_make");
    chk("make_pressed", 32'(key_pressed), 32'd1);
    chk("make_count", 32'(press_count), 32'd1);

    // make then break
    push_byte(8'hF0); push_byte(8'h1C);
    drain("break");
    chk("break_pressed", 32'(key_pressed), 32'd0);
    chk("break_count", 32'(press_count), 32'd1);

    // extended make / break
    push_byte(8'hE0); push_byte(8'h75);
    push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
    drain("ext");
    chk("ext_pressed", 32'(key_pressed), 32'd0);

    // mismatched break leaves the held key pressed
    push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h22);
    drain("mismatch");
    chk("mismatch_pressed", 32'(key_pressed), 32'd1);
    push_byte(8'hF0); push_byte(8'h1C);
    drain("release");

    // typematic repeat
    ev0 = events; pop0 = pops;
    push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C);
    drain("repeat");
    chk("repeat_pops", 32'(pops - pop0), 32'd3);
`ifdef PS2SEQ_REPEAT_FILTER_EN
    chk("repeat_events", 32'(events - ev0), 32'd1);
`else
    chk("repeat_events", 32'(events - ev0), 32'd3);
`endif
    push_byte(8'hF0); push_byte(8'h1C);
    drain("repeat_release");

    // counter wrap: 256 make/break pairs
    cnt0 = int'(press_count);
    for (int i = 0; i < 256; i++) begin
      push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
    end
    drain("wrap");
    chk("wrap_count", 32'(press_count), 32'(cnt0));

    // randomized byte stream
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) push_byte(8'hE0);
      else if (r < 4) push_byte(8'hF0);
      else if (r < 7) begin
        case ($urandom_range(0, 2))
          0: push_byte(8'h1C);
          1: push_byte(8'h22);
          default: push_byte(8'h75);
        endcase
      end else push_byte(8'($urandom_range(0, 255)));
    end
    drain("random");
    chk("random_pressed", 32'(key_pressed), 32'(m_pressed));
    chk("random_count", 32'(press_count), 32'(m_count));

    // overflow sticky
    @(negedge clk); bus.overflow = 1'b1;
    @(negedge clk); bus.overflow = 1'b0;
    chk("ovf_set", 32'(ovf_sticky), 32'd1);
    bus.overflow = 1'b1; clear_ovf = 1'b1;
    @(negedge clk); bus.overflow = 1'b0; clear_ovf = 1'b0;
    chk("ovf_set_wins", 32'(ovf_sticky), 32'd1);
    @(negedge clk);
    chk("ovf_hold", 32'(ovf_sticky), 32'd1);
    clear_ovf = 1'b1;
    @(negedge clk); clear_ovf = 1'b0;
    chk("ovf_clear", 32'(ovf_sticky), 32'd0);

    // asynchronous reset in the middle of a pop
    push_byte(8'h22);
    r = 0;
    for (int i = 0; i < 50 && !r; i++) begin
      @(negedge clk);
      if (bus.nextdata_n == 1'b0) r = 1;
    end
    chk("midpop_seen", 32'(r), 32'd1);
    #2 clrn = 1'b0;
    #1;
    chk("midpop_nextdata_n", 32'(bus.nextdata_n), 32'd1);
    chk("midpop_outputs", {key_event, key_make, key_ext, key_code, key_pressed}, 32'd0);
    chk("midpop_count", 32'(press_count), 32'd0);
    model_reset();
    @(negedge clk); clrn = 1'b1;
    push_byte(8'hE0); push_byte(8'h75);
    drain("post_reset");
    chk("post_reset_count", 32'(press_count), 32'd1);
    chk("post_reset_pressed", 32'(key_pressed), 32'd1);

    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("total_events", 32'(events), 32'(exp_evts));
    chk("total_pops", 32'(pops), 32'(pushed));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
